// File: rtl/miner_job_ctrl_if.sv
// Host and lane signals of the miner job controller, grouped so the controller
// and its environment share one bundle. "master" drives job/lane inputs, "slave" is the controller.
interface miner_job_ctrl_if #(
  parameter int NUM_LANES = 4
);
  logic                      start_found;
  logic                      shift_in_enable;
  logic [31:0]               in_data;
  logic                      stop_on_first;
  logic                      sol_response;
  logic                      sol_claim;
  logic [31:0]               out_data;
  logic [255:0]              mid_data;
  logic [511:0]              head_data;
  logic                      lane_run;
  logic [32*NUM_LANES-1:0]   lane_nonce_base;
  logic [NUM_LANES-1:0]      lane_found;
  logic [32*NUM_LANES-1:0]   lane_nonce;
  logic [NUM_LANES-1:0]      lane_done;
  logic [NUM_LANES-1:0]      lane_ack;
  logic [2:0]                state;
  logic [31:0]               found_count;

  modport master (
    output start_found, shift_in_enable, in_data, stop_on_first, sol_response,
    output lane_found, lane_nonce, lane_done,
    input  sol_claim, out_data, mid_data, head_data, lane_run, lane_nonce_base,
    input  lane_ack, state, found_count
  );

  modport slave (
    input  start_found, shift_in_enable, in_data, stop_on_first, sol_response,
    input  lane_found, lane_nonce, lane_done,
    output sol_claim, out_data, mid_data, head_data, lane_run, lane_nonce_base,
    output lane_ack, state, found_count
  );
endinterface

// File: rtl/miner_job_ctrl.sv
// Job loader, lane sequencer and golden-nonce FIFO for a multi-lane miner.
// Lanes present finds; the lowest-indexed one is accepted per cycle into the FIFO.
module miner_job_ctrl #(
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  miner_job_ctrl_if.slave bus
);
  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int SHIFT     = 32 - LANE_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_MID  = 3'd1,
    LOAD_HEAD = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state_q;
  logic [3:0]          word_cnt_q;
  logic [255:0]        mid_q;
  logic [511:0]        head_q;
  logic                run_q;
  logic [31:0]         found_q;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                fifo_full;
  logic                pop;
  logic                accept_en;
  logic                push;
  logic                run_exit;
  logic [NUM_LANES-1:0] ack;
  logic [31:0]         push_nonce;
  logic [32*NUM_LANES-1:0] base_vec;

  // In stop-on-first mode only one solution is taken, even in the exit cycle.
  always_comb begin
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = bus.sol_response && (count_q != '0) && !bus.start_found;
    accept_en  = (state_q == RUN) && !bus.start_found &&
                 !(bus.stop_on_first && (found_q != '0)) &&
                 (!fifo_full || pop);
    ack        = '0;
    push_nonce = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (accept_en && bus.lane_found[i]) begin
        ack        = '0;
        ack[i]     = 1'b1;
        push_nonce = bus.lane_nonce[32*i +: 32];
      end
    end
    push     = |ack;
    run_exit = (&bus.lane_done) || (bus.stop_on_first && (found_q != '0));
  end

  always_comb begin
    base_vec = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      base_vec[32*i +: 32] = 32'(64'(i) << SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_nonce;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      mid_q      <= '0;
      head_q     <= '0;
      run_q      <= 1'b0;
      found_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (bus.start_found) begin
      state_q    <= LOAD_MID;
      word_cnt_q <= '0;
      mid_q      <= '0;
      head_q     <= '0;
      run_q      <= 1'b0;
      found_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (push && (found_q != '1)) begin
        found_q <= found_q + 32'd1;
      end

      case (state_q)
        LOAD_MID: begin
          if (bus.shift_in_enable) begin
            mid_q <= {mid_q[223:0], bus.in_data};
            if (word_cnt_q == 4'd7) begin
              word_cnt_q <= '0;
              state_q    <= LOAD_HEAD;
            end else begin
              word_cnt_q <= word_cnt_q + 4'd1;
            end
          end
        end
        LOAD_HEAD: begin
          if (bus.shift_in_enable) begin
            head_q <= {head_q[479:0], bus.in_data};
            if (word_cnt_q == 4'd15) begin
              word_cnt_q <= '0;
              state_q    <= RUN;
              run_q      <= 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + 4'd1;
            end
          end
        end
        RUN: begin
          if (run_exit) begin
            state_q <= DONE;
            run_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.lane_ack        = ack;
  assign bus.sol_claim       = (count_q != '0);
  assign bus.out_data        = (count_q != '0) ? fifo_mem[rd_ptr_q] : 32'h0;
  assign bus.mid_data        = mid_q;
  assign bus.head_data       = head_q;
  assign bus.lane_run        = run_q;
  assign bus.lane_nonce_base = base_vec;
  assign bus.state           = state_q;
  assign bus.found_count     = found_q;
endmodule

// File: tb/tb_miner_job_ctrl.sv
// Bench for miner_job_ctrl: directed test-plan scenarios plus random lane/host traffic,
// checked by a queue-based reference model and a scoreboard on the FIFO contents.
module tb_miner_job_ctrl;
  localparam int NL = 4;
  localparam int FD = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  miner_job_ctrl_if #(.NUM_LANES(NL)) bus ();
  miner_job_ctrl #(.NUM_LANES(NL), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Reference model: job phase, word count, FIFO as a queue of expected nonces.
  int                m_state;
  int                m_words;
  bit                m_run;
  longint unsigned   m_found;
  logic [31:0]       sb_q[$];
  logic [NL-1:0]     ack_seen;
  logic [NL-1:0]     m_exp_ack;
  bit                m_push;
  bit                m_pop;
  bit                m_exit;
  logic [31:0]       m_push_val;
  logic [31:0]       m_head;
  logic [31:0]       jw[24];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      m_state = 0;
      m_words = 0;
      m_run   = 1'b0;
      m_found = 0;
      sb_q.delete();
      ack_seen = '0;
    end else begin
      m_head = 32'h0;
      if (sb_q.size() != 0) m_head = sb_q[0];
      check("state", 512'(bus.state), 512'(m_state));
      check("lane_run", 512'(bus.lane_run), 512'(m_run));
      check("sol_claim", 512'(bus.sol_claim), 512'(sb_q.size() != 0));
      check("out_data", 512'(bus.out_data), 512'(m_head));
      check("found_count", 512'(bus.found_count), 512'(m_found));
      if (bus.start_found) begin
        m_state = 1;
        m_words = 0;
        m_run   = 1'b0;
        m_found = 0;
        sb_q.delete();
      end else begin
        m_exp_ack = '0;
        m_push    = 1'b0;
        m_pop     = bus.sol_response && (sb_q.size() != 0);
        if (m_state == 3 && !(bus.stop_on_first && m_found != 0) &&
            (sb_q.size() < FD || m_pop)) begin
          for (int i = 0; i < NL; i++) begin
            if (bus.lane_found[i] && !m_push) begin
              m_push       = 1'b1;
              m_exp_ack[i] = 1'b1;
              m_push_val   = bus.lane_nonce[32*i +: 32];
            end
          end
        end
        check("lane_ack", 512'(bus.lane_ack), 512'(m_exp_ack));
        m_exit = (m_state == 3) && ((&bus.lane_done) || (bus.stop_on_first && m_found != 0));
        if (m_pop) begin
          $display("[TB] host pop nonce %08h", sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (m_push) begin
          $display("[TB] lane ack %b nonce %08h", m_exp_ack, m_push_val);
          sb_q.push_back(m_push_val);
          if (m_found < 64'hFFFF_FFFF) m_found++;
        end
        case (m_state)
          1: if (bus.shift_in_enable) begin
               m_words++;
               if (m_words == 8) begin m_state = 2; m_words = 0; end
             end
          2: if (bus.shift_in_enable) begin
               m_words++;
               if (m_words == 16) begin m_state = 3; m_words = 0; m_run = 1'b1; end
             end
          3: if (m_exit) begin m_state = 4; m_run = 1'b0; end
          default: ;
        endcase
      end
      ack_seen = bus.lane_ack;
    end
  end

  // One clock; lanes drop lane_found once acked, host strobes are one-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.lane_found      = bus.lane_found & ~ack_seen;
    bus.start_found     = 1'b0;
    bus.shift_in_enable = 1'b0;
    bus.sol_response    = 1'b0;
  endtask

  task automatic load_job(input int gap);
    int g;
    bus.start_found     = 1'b1;
    bus.shift_in_enable = 1'b1;
    bus.in_data         = 32'hDEAD_BEEF;
    tick();
    check("start_state", 512'(bus.state), 512'(1));
    for (int k = 0; k < 24; k++) begin
      bus.shift_in_enable = 1'b1;
      bus.in_data         = jw[k];
      tick();
      if (k == 7) check("mid_to_head", 512'(bus.state), 512'(2));
      if (k == 23) begin
        check("head_to_run", 512'(bus.state), 512'(3));
        check("run_rise", 512'(bus.lane_run), 512'(1));
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int s = 0; s < g; s++) tick();
    end
  endtask

  task automatic check_job();
    logic [255:0] em;
    logic [511:0] eh;
    for (int k = 0; k < 8; k++) em[255-32*k -: 32] = jw[k];
    for (int k = 0; k < 16; k++) eh[511-32*k -: 32] = jw[8+k];
    check("mid_data", 512'(bus.mid_data), 512'(em));
    check("head_data", bus.head_data, eh);
  endtask

  task automatic rand_words();
    for (int k = 0; k < 24; k++) jw[k] = $urandom;
  endtask

  task automatic rand_run(input int cycles, input int pop_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (!bus.lane_found[i] && $urandom_range(0, 99) < 20) begin
          bus.lane_nonce[32*i +: 32] = $urandom;
          bus.lane_found[i] = 1'b1;
        end
      end
      bus.sol_response = ($urandom_range(0, 99) < pop_pct);
      tick();
    end
  endtask

  task automatic finish_and_drain(input string tag);
    bus.lane_done = '1;
    tick();
    check({tag, "_done"}, 512'(bus.state), 512'(4));
    for (int c = 0; c < 20 && bus.sol_claim; c++) begin
      bus.sol_response = 1'b1;
      tick();
    end
    check({tag, "_drained"}, 512'(bus.sol_claim), 512'(0));
    bus.lane_found = '0;
    bus.lane_done  = '0;
  endtask

  initial begin
    bus.start_found     = 1'b0;
    bus.shift_in_enable = 1'b0;
    bus.in_data         = '0;
    bus.stop_on_first   = 1'b0;
    bus.sol_response    = 1'b0;
    bus.lane_found      = '0;
    bus.lane_nonce      = '0;
    bus.lane_done       = '0;

    repeat (3) @(posedge clk);
    #3;
    check("rst_state", 512'(bus.state), 512'(0));
    check("rst_claim", 512'(bus.sol_claim), 512'(0));
    check("rst_out", 512'(bus.out_data), 512'(0));
    check("rst_run", 512'(bus.lane_run), 512'(0));
    check("rst_ack", 512'(bus.lane_ack), 512'(0));
    check("rst_mid", 512'(bus.mid_data), 512'(0));
    check("rst_head", bus.head_data, 512'(0));
    for (int i = 0; i < NL; i++)
      check($sformatf("base%0d", i), 512'(bus.lane_nonce_base[32*i +: 32]),
            512'(longint'(i) * (64'h1_0000_0000 / NL)));
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Sequential job words, then a stray word in RUN that must be ignored.
    for (int k = 0; k < 24; k++)
      jw[k] = (k < 8) ? 32'h1000_0000 + 32'(k) : 32'h2000_0000 + 32'(k - 8);
    load_job(0);
    check_job();
    check("mid_top", 512'(bus.mid_data[255:224]), 512'(32'h1000_0000));
    check("head_low", 512'(bus.head_data[31:0]), 512'(32'h2000_000F));
    bus.shift_in_enable = 1'b1;
    bus.in_data         = 32'hFFFF_FFFF;
    tick();
    check_job();

    // Same job with idle gaps between words.
    load_job(3);
    check_job();

    // Simultaneous finds on lanes 2 and 0.
    bus.lane_nonce[95:64] = 32'hAAAA_0000;
    bus.lane_nonce[31:0]  = 32'h0000_BEEF;
    bus.lane_found        = 4'b0101;
    @(negedge clk); #1;
    check("ack_first", 512'(bus.lane_ack), 512'(4'b0001));
    tick();
    @(negedge clk); #1;
    check("ack_second", 512'(bus.lane_ack), 512'(4'b0100));
    tick();
    check("head_beef", 512'(bus.out_data), 512'(32'h0000_BEEF));
    check("claim_set", 512'(bus.sol_claim), 512'(1));
    bus.sol_response = 1'b1;
    tick();
    check("head_aaaa", 512'(bus.out_data), 512'(32'hAAAA_0000));
    check("count_two", 512'(bus.found_count), 512'(2));
    bus.sol_response = 1'b1;
    tick();
    check("claim_clear", 512'(bus.sol_claim), 512'(0));

    // Fill the FIFO, then a fifth find must wait for a pop.
    bus.lane_nonce = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    bus.lane_found = 4'hF;
    repeat (4) tick();
    check("count_six", 512'(bus.found_count), 512'(6));
    bus.lane_nonce[31:0] = 32'h0000_0055;
    bus.lane_found       = 4'b0001;
    @(negedge clk); #1;
    check("ack_full", 512'(bus.lane_ack), 512'(0));
    tick();
    @(negedge clk); #1;
    check("ack_full2", 512'(bus.lane_ack), 512'(0));
    tick();
    bus.sol_response = 1'b1;
    @(negedge clk); #1;
    check("ack_on_pop", 512'(bus.lane_ack), 512'(4'b0001));
    tick();
    check("count_seven", 512'(bus.found_count), 512'(7));
    repeat (4) begin
      bus.sol_response = 1'b1;
      tick();
    end
    check("fifo_held_4", 512'(bus.sol_claim), 512'(0));

    // Stop on first solution; a later find is not taken.
    bus.stop_on_first = 1'b1;
    rand_words();
    load_job(0);
    bus.lane_nonce[63:32] = 32'h1234_5678;
    bus.lane_found        = 4'b0010;
    @(negedge clk); #1;
    check("sof_ack", 512'(bus.lane_ack), 512'(4'b0010));
    tick();
    bus.lane_nonce[127:96] = 32'h0000_9999;
    bus.lane_found         = 4'b1000;
    @(negedge clk); #1;
    check("sof_no_ack", 512'(bus.lane_ack), 512'(0));
    check("sof_still_run", 512'(bus.lane_run), 512'(1));
    tick();
    check("sof_done", 512'(bus.state), 512'(4));
    check("sof_run_low", 512'(bus.lane_run), 512'(0));
    tick();
    bus.lane_found    = '0;
    bus.stop_on_first = 1'b0;
    bus.sol_response  = 1'b1;
    tick();

    // All lanes exhausted, then abort a run holding two results.
    rand_words();
    load_job(0);
    bus.lane_done = '1;
    tick();
    check("alldone", 512'(bus.state), 512'(4));
    bus.lane_done = '0;
    rand_words();
    load_job(1);
    check_job();
    bus.lane_nonce[31:0]  = 32'hCAFE_0001;
    bus.lane_nonce[63:32] = 32'hCAFE_0002;
    bus.lane_found        = 4'b0011;
    tick();
    tick();
    check("two_held", 512'(bus.found_count), 512'(2));
    bus.start_found = 1'b1;
    tick();
    check("abort_claim", 512'(bus.sol_claim), 512'(0));
    check("abort_count", 512'(bus.found_count), 512'(0));
    check("abort_state", 512'(bus.state), 512'(1));

    // Random job, random traffic, then asynchronous reset mid-run.
    rand_words();
    load_job(-1);
    check_job();
    rand_run(60, 20);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_state", 512'(bus.state), 512'(0));
    check("arst_run", 512'(bus.lane_run), 512'(0));
    check("arst_claim", 512'(bus.sol_claim), 512'(0));
    check("arst_count", 512'(bus.found_count), 512'(0));
    check("arst_mid", 512'(bus.mid_data), 512'(0));
    bus.lane_found   = '0;
    bus.sol_response = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Two more random jobs with varied host pop rates.
    for (int j = 0; j < 2; j++) begin
      rand_words();
      load_job(-1);
      check_job();
      rand_run(150, (j == 0) ? 15 : 60);
      finish_and_drain($sformatf("rjob%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/miner_job_ctrl.md
Name: miner_job_ctrl

Overview:
- Job controller and solution collector for a multi-lane Bitcoin miner.
- Loads one job from the host over the 32-bit word interface: an 8-word midstate, then a 16-word header block.
- Splits the 2^32 nonce space evenly across NUM_LANES external SHA lanes and runs them.
- Collects golden nonces from the lanes through a result FIFO and presents them to the host with a claim/response handshake.

Parameters:
- NUM_LANES, 4, number of SHA lanes. Power of 2, range 1..16.
- FIFO_DEPTH, 4, result FIFO entries. Power of 2, range 2..16.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start_found  in  1  new-job strobe; aborts any current job
- shift_in_enable  in  1  qualifies in_data as one job word
- in_data  in  32  job word
- stop_on_first  in  1  mode: halt all lanes after the first accepted solution
- sol_response  in  1  host pop strobe for the FIFO head
- sol_claim  out  1  FIFO non-empty
- out_data  out  32  FIFO head nonce
- mid_data  out  256  loaded midstate
- head_data  out  512  loaded header block
- lane_run  out  1  lanes hash while high
- lane_nonce_base  out  32*NUM_LANES  start nonce per lane; lane i occupies bits [32i+31:32i]
- lane_found  in  NUM_LANES  lane i holds a golden nonce
- lane_nonce  in  32*NUM_LANES  nonce from lane i
- lane_done  in  NUM_LANES  lane i slice exhausted (level)
- lane_ack  out  NUM_LANES  one-hot acceptance pulse
- state  out  3  IDLE=0, LOAD_MID=1, LOAD_HEAD=2, RUN=3, DONE=4
- found_count  out  32  solutions accepted this job, saturating at 0xFFFFFFFF

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0; FIFO empty.
  - lane_nonce_base is constant: i * 2^(32-log2 NUM_LANES). Lane 0 base = 0.
- start_found, any state:
  - Next cycle: mid_data, head_data, FIFO, found_count and word counter clear; lane_run = 0; state = LOAD_MID.
  - A shift_in_enable in the same cycle is ignored.
- Word loading:
  - Each qualified word shifts the active register left by 32; the new word enters bits [31:0].
  - The first word ends in the top word position.
- LOAD_MID:
  - Exactly 8 qualified words.
  - The cycle after the 8th word: state = LOAD_HEAD.
- LOAD_HEAD:
  - Exactly 16 qualified words.
  - The cycle after the 16th word: state = RUN and lane_run = 1.
- shift_in_enable is ignored in IDLE, RUN and DONE. mid_data and head_data hold until the next start_found.
- RUN:
  - lane_run = 1.
  - Exits when all lane_done bits are 1, or when stop_on_first = 1 and a solution has been accepted.
  - Next cycle: state = DONE and lane_run = 0.
- DONE:
  - Holds the FIFO for host draining; stays until start_found.
- Lane acceptance:
  - Each cycle, the lowest-indexed lane with lane_found = 1 gets lane_ack for one cycle, provided the FIFO can accept.
  - The FIFO can accept when count < FIFO_DEPTH, or when it is full and sol_response pops in the same cycle.
  - Its lane_nonce is written to the FIFO tail that cycle. Lanes hold lane_found and lane_nonce until acked.
  - Acceptance happens only in RUN, and in the single cycle in which RUN exits.
  - Simultaneous finds are serviced one per cycle in index order.
  - FIFO full without a pop: no ack, so lanes stall.
- found_count increments on each ack.
- Host interface:
  - sol_claim = FIFO non-empty; out_data = FIFO head, or 0 when empty. Both are registered-path outputs valid the cycle after a push.
  - sol_response on non-empty: pops the head, one entry per cycle.
  - sol_response on empty: ignored.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
- Reset mid-operation: all state clears immediately, asynchronously.

Test Plan:
- Load words 0x1000_0000..0x1000_0007, then 0x2000_0000..0x2000_000F, one per cycle:
  - mid_data[255:224] = 0x1000_0000 and [31:0] = 0x1000_0007; head_data[31:0] = 0x2000_000F.
  - state 1→2→3; lane_run rises the cycle after the 24th word.
  - NUM_LANES = 4: bases are 0, 0x4000_0000, 0x8000_0000, 0xC000_0000.
- Stalled loading: insert 3 idle cycles between words → same final contents; no extra shifts.
- In RUN, lanes 2 and 0 assert lane_found together with nonces 0xAAAA_0000 and 0x0000_BEEF:
  - lane_ack = 0001, then 0100 on the next cycle.
  - out_data = 0x0000_BEEF with sol_claim = 1.
  - After the pop, out_data = 0xAAAA_0000; found_count = 2.
- FIFO_DEPTH = 4, 5 finds, no response:
  - The 5th lane stays un-acked.
  - A sol_response pulse acks it in the same cycle; the FIFO stays at 4 entries.
- stop_on_first = 1, a single find → lane_run drops and state = 4 two cycles after the ack. A second lane's find is not acked.
- All lane_done → DONE. start_found mid-RUN with a FIFO holding 2 entries → next cycle sol_claim = 0, found_count = 0, state = 1.
